// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the 1-cycle-latency imem address and buffers words for decode.
// Optional halt-word detection is enabled by defining FETCH_HALT_EN.
module fetch_sequencer #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [31:0]     HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     instructionIn,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic {
    FETCH,
    HALTED
  } state_t;

  state_t state, state_nxt;

  logic            pending;
  logic [PC_W-1:0] tag;
  logic [31:0]     buf_instr [FIFO_DEPTH];
  logic [PC_W-1:0] buf_pc    [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            deq, enq, issue, halt_hit;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign if_valid = (count != '0);
  assign deq      = if_valid & if_ready;
  assign halt_hit = HALT_EN & pending
                  & (instructionIn == HALT_WORD);
  assign enq      = pending & ~redirect_valid & ~halt_hit;

  // occupancy once the in-flight word lands, net of this cycle's dequeue
  assign occ = {1'b0, count}
             + {{CW{1'b0}}, pending}
             - {{CW{1'b0}}, deq};

  assign issue = (state == FETCH) & run
               & ~redirect_valid & ~halt_hit
               & (occ < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid)
      state_nxt = FETCH;
    else if (halt_hit)
      state_nxt = HALTED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      pending <= 1'b0;
      tag     <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        tag <= pc;
        pc  <= pc + 1'b1;
      end
      if (redirect_valid) begin
        pc     <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= ptr_inc(wr_ptr);
        if (deq) rd_ptr <= ptr_inc(rd_ptr);
        if (enq & ~deq)
          count <= count + 1'b1;
        else if (deq & ~enq)
          count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_instr[wr_ptr] <= instructionIn;
      buf_pc[wr_ptr]    <= tag;
    end
  end

  assign if_instr = if_valid ? buf_instr[rd_ptr] : '0;
  assign if_pc    = if_valid ? buf_pc[rd_ptr] : '0;

`ifdef FETCH_HALT_EN
  assign halted = (state == HALTED);
`else
  assign halted = 1'b0;
`endif

endmodule
